// File: rtl/lock_dialer_if.sv
// Controller <-> dialer bundle for lock_dialer.
// The controller side (master) issues start/abort and the combination.
// The dialer side (slave) drives up/down and reports status and position.
interface lock_dialer_if #(
   parameter int MSB = 6
);
   logic         start;
   logic         abort;
   logic [MSB:0] c0;
   logic [MSB:0] c1;
   logic [MSB:0] c2;
   logic         up;
   logic         down;
   logic         busy;
   logic         done;
   logic [MSB:0] position;

   modport master (
      output start, abort, c0, c1, c2,
      input  up, down, busy, done, position
   );

   modport slave (
      input  start, abort, c0, c1, c2,
      output up, down, busy, done, position
   );
endinterface

// File: rtl/lock_dialer.sv
// lock_dialer: drives a lock's up/down step lines so that a three-number
// combination is entered automatically.
//
// The sequence is: reach C0 clockwise, then C1 counterclockwise, then C2
// clockwise, then hold still. At most one notch is emitted per clock.
// The block keeps its own copy of the dial position, which mirrors the
// lock's position counter and already includes the step currently shown
// on up/down.
//
// Optional build macro LOCK_DIALER_SHORTEST_EN: on start, the approach to
// C0 takes whichever is strictly shorter -- counting up to C0, or counting
// down to C0-1 followed by one up step. A tie takes the up path.
// Without the macro, the down pre-step is used only when the position
// already equals C0.
module lock_dialer #(
   parameter int           MSB      = 6,
   parameter logic [MSB:0] INIT_POS = '0
) (
   input logic          clock,
   input logic          reset_n,
   lock_dialer_if.slave bus
);

   localparam logic [MSB:0] ONE = {{MSB{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t       state_q, state_d;
   logic [MSB:0] pos_q, pos_d;
   logic [MSB:0] c0_q, c0_d;
   logic [MSB:0] c1_q, c1_d;
   logic [MSB:0] c2_q, c2_d;
   logic         up_q, up_d;
   logic         down_q, down_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [MSB:0] pos_inc;
   logic [MSB:0] pos_dec;
   logic [MSB:0] c0_before;
   logic         take_down_path;

   assign pos_inc   = pos_q + ONE;
   assign pos_dec   = pos_q - ONE;
   assign c0_before = c0_q - ONE;

`ifdef LOCK_DIALER_SHORTEST_EN
   // Up path: (c0 - p) ups. Down path: downs to c0-1 plus one final up.
   // Both paths are evaluated against the c0 presented with start.
   logic [MSB:0]   up_len;
   logic [MSB:0]   down_gap;
   logic [MSB+1:0] down_len;

   assign up_len         = bus.c0 - pos_q;
   assign down_gap       = pos_q - (bus.c0 - ONE);
   assign down_len       = {1'b0, down_gap} + {{(MSB+1){1'b0}}, 1'b1};
   assign take_down_path = (pos_q == bus.c0) || (down_len < {1'b0, up_len});
`else
   // C0 must be arrived at by an up step, so starting on C0 needs one down.
   assign take_down_path = (pos_q == bus.c0);
`endif

   // Next-state, step and status decode.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      up_d    = 1'b0;
      down_d  = 1'b0;

      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  c0_d    = bus.c0;
                  c1_d    = bus.c1;
                  c2_d    = bus.c2;
                  state_d = take_down_path ? PRE : P1;
               end
            end
            PRE: begin
               // Keep stepping down until one notch below C0.
               down_d = 1'b1;
               pos_d  = pos_dec;
               if (pos_dec == c0_before) begin
                  state_d = P1;
               end
            end
            P1: begin
               up_d  = 1'b1;
               pos_d = pos_inc;
               if (pos_inc == c0_q) begin
                  state_d = P2;
               end
            end
            P2: begin
               // Always at least one step, so C1==C0 is a full revolution.
               down_d = 1'b1;
               pos_d  = pos_dec;
               if (pos_dec == c1_q) begin
                  state_d = P3;
               end
            end
            P3: begin
               up_d  = 1'b1;
               pos_d = pos_inc;
               if (pos_inc == c2_q) begin
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // busy covers the final up step; done rises the cycle after it.
      busy_d = (state_d inside {PRE, P1, P2, P3}) ||
               ((state_d == DONE) && (state_q == P3));
      done_d = (state_d == DONE) && (state_q == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pos_q   <= INIT_POS;
         c0_q    <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         up_q    <= up_d;
         down_q  <= down_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.up       = up_q;
   assign bus.down     = down_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.position = pos_q;

endmodule

// File: tb/tb_lock_dialer.sv
// Testbench for lock_dialer (MSB=6, INIT_POS=0).
// Stimulus pushes the expected step stream into a queue; a monitor on the
// falling clock edge pops and compares every emitted step and done event.
module tb_lock_dialer;

   localparam int MSB    = 6;
   localparam int MOD    = 128;
   localparam int K_UP   = 1;
   localparam int K_DOWN = 2;
   localparam int K_DONE = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   lock_dialer_if #(.MSB(MSB)) bus();

   lock_dialer #(
      .MSB      (MSB),
      .INIT_POS (7'd0)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int kind;
      int pos;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mpos     = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_steps(input int kind, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         mpos   = (kind == K_UP) ? (mpos + 1) % MOD : (mpos + MOD - 1) % MOD;
         e.kind = kind;
         e.pos  = mpos;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_done();
      exp_t e;
      e.kind = K_DONE;
      e.pos  = mpos;
      exp_q.push_back(e);
   endtask

   // Monitor: every step and every rising done is matched against the queue.
   always @(negedge clock) begin
      exp_t e;
      if (bus.up === 1'b1 || bus.down === 1'b1) begin
         chk("up_down_exclusive", int'(bus.up && bus.down), 0);
         chk("busy_during_step", int'(bus.busy), 1);
         chk("step_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("step_dir", bus.up ? K_UP : K_DOWN, e.kind);
            chk("step_pos", int'(bus.position), e.pos);
         end
      end
      if (bus.done === 1'b1 && done_prev !== 1'b1) begin
         chk("done_expected", int'(exp_q.size() > 0), 1);
         chk("done_busy", int'(bus.busy), 0);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_kind", K_DONE, e.kind);
            chk("done_pos", int'(bus.position), e.pos);
         end
      end
      done_prev = bus.done;
   end

   task automatic pulse_start(input int c0, input int c1, input int c2);
      @(negedge clock);
      bus.c0    = 7'(c0);
      bus.c1    = 7'(c1);
      bus.c2    = 7'(c2);
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      // Scramble inputs to show the combination was captured at start.
      bus.c0 = ~bus.c0;
      bus.c1 = ~bus.c1;
      bus.c2 = ~bus.c2;
   endtask

   // Full sequence with hand-computed step counts per phase.
   task automatic run_seq(input string name, input int c0, input int c1, input int c2,
                          input int npre, input int np1, input int np2, input int np3);
      int total;
      int cyc;
      total = npre + np1 + np2 + np3;
      push_steps(K_DOWN, npre);
      push_steps(K_UP, np1);
      push_steps(K_DOWN, np2);
      push_steps(K_UP, np3);
      push_done();
      pulse_start(c0, c1, c2);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 2000) begin
         @(posedge clock);
         cyc++;
         #1;
      end
      chk({name, "_latency"}, cyc, total + 1);
      @(negedge clock);
      #1;
      chk({name, "_queue_empty"}, exp_q.size(), 0);
      chk({name, "_final_pos"}, int'(bus.position), c2);
      $display("seq %s: c=%0d/%0d/%0d steps=%0d cycles=%0d pos=%0d", name, c0, c1, c2,
               total, cyc, bus.position);
   endtask

   task automatic check_quiet(input string name, input int pos);
      chk({name, "_up"}, int'(bus.up), 0);
      chk({name, "_down"}, int'(bus.down), 0);
      chk({name, "_busy"}, int'(bus.busy), 0);
      chk({name, "_done"}, int'(bus.done), 0);
      chk({name, "_pos"}, int'(bus.position), pos);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.c0    = '0;
      bus.c1    = '0;
      bus.c2    = '0;

      // Reset state.
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_quiet("reset", 0);
      reset_n = 1'b1;
      $display("reset: pos=%0d", bus.position);

      // Main combination from position 0, then hold open for 10 cycles.
      run_seq("t1", 12, 21, 15, 0, 12, 119, 122);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("hold_up", int'(bus.up), 0);
         chk("hold_down", int'(bus.down), 0);
         chk("hold_done", int'(bus.done), 1);
         chk("hold_pos", int'(bus.position), 15);
      end

      // Start while already on C0: one down first, then one up.
      run_seq("t2", 15, 0, 3, 1, 1, 15, 3);

      // C1==C0 and C2==C1: full revolutions in P2 and P3.
      run_seq("t3", 5, 5, 5, 0, 2, 128, 128);

      // Abort mid-P2 after 35 ups and 10 downs.
      push_steps(K_UP, 35);
      push_steps(K_DOWN, 10);
      pulse_start(40, 100, 7);
      repeat (45) @(posedge clock);
      #1;
      bus.abort = 1'b1;
      @(posedge clock);
      #1;
      bus.abort = 1'b0;
      @(negedge clock);
      check_quiet("abort", 30);
      chk("abort_queue_empty", exp_q.size(), 0);
      repeat (5) @(negedge clock);
      chk("abort_pos_frozen", int'(bus.position), mpos);
      $display("seq abort: pos=%0d", bus.position);

      // Fresh sequence from the retained position.
      run_seq("t5", 50, 20, 25, 0, 20, 30, 5);

      // Start pulsed while busy (ignored), then reset during P1.
      push_steps(K_UP, 10);
      pulse_start(60, 1, 2);
      repeat (3) @(posedge clock);
      #1;
      bus.c0    = 7'd26;
      bus.c1    = 7'd26;
      bus.c2    = 7'd26;
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      mpos    = 0;
      @(negedge clock);
      check_quiet("midreset", 0);
      chk("midreset_queue_empty", exp_q.size(), 0);
      $display("seq midreset: pos=%0d", bus.position);

      // C0 equal to position 0: down to 127, up to 0, full revolutions.
      run_seq("t7", 0, 0, 0, 1, 1, 128, 128);

      // Move to position 20, then approach C0=12 from there.
      run_seq("t8", 20, 10, 20, 0, 20, 10, 10);
`ifdef LOCK_DIALER_SHORTEST_EN
      run_seq("t9", 12, 12, 13, 9, 1, 128, 1);
`else
      run_seq("t9", 12, 12, 13, 0, 120, 128, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
